arf054b256e1r1w0cbbeheaa4acw_wr_stage: RTL and testbench



---
 rtl/arf054b256e1r1w0cbbeheaa4acw_pkg.sv | 10 +
 rtl/arf054b256e1r1w0cbbeheaa4acw_wr_dec.sv | 24 ++
 rtl/arf054b256e1r1w0cbbeheaa4acw_wr_stage.sv | 87 ++++++++
 tb/tb_arf054b256e1r1w0cbbeheaa4acw_wr_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_pkg.sv
// Shared sizes and types for the 256-entry 1R1W register file write path.
package arf054b256e1r1w0cbbeheaa4acw_pkg;
  localparam int DWIDTH_C = 54;
  localparam int DEPTH_C  = 256;
  localparam int AWIDTH_C = 8;

  typedef logic [AWIDTH_C-1:0] addr_t;
  typedef logic [DWIDTH_C-1:0] data_t;
  typedef logic [DEPTH_C-1:0]  sel_t;
endpackage

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_wr_dec.sv
// Combinational address-to-one-hot decoder with in-range qualifier; shared with the read side.
module arf054b256e1r1w0cbbeheaa4acw_wr_dec
  import arf054b256e1r1w0cbbeheaa4acw_pkg::*;
#(
  parameter int DEPTH  = DEPTH_C,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic [AWIDTH-1:0] addr,
  output logic [DEPTH-1:0]  sel,
  output logic              in_range
);

  // A full power-of-two array can never see an out-of-range index.
  if (DEPTH == (1 << AWIDTH)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_partial
    assign in_range = ({1'b0, addr} < (AWIDTH+1)'(DEPTH));
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_sel
    assign sel[i] = (addr == AWIDTH'(i));
  end

endmodule

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_wr_stage.sv
// Write-port staging for the phase-B latch array: flops the request, drives low-phase latch enables.
// Optional same-cycle bypass compare enabled by ARF054B256E1R1W0CBBEHEAA4ACW_WR_BYPASS_EN.
module arf054b256e1r1w0cbbeheaa4acw_wr_stage
  import arf054b256e1r1w0cbbeheaa4acw_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_C,
  parameter int DEPTH  = DEPTH_C,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] lat_d,
  output logic [DEPTH-1:0]  lat_en_b,
  output logic              byp_hit,
  output logic [DWIDTH-1:0] byp_data,
  output logic              wr_addr_err,
  output logic              wr_busy
);

  logic [DEPTH-1:0]  dec_sel;
  logic              dec_ok;
  logic              wr_ok;
  logic              vld_p1;
  logic [DEPTH-1:0]  sel_p1;
  logic [DWIDTH-1:0] data_p1;
  logic              err_p1;

  arf054b256e1r1w0cbbeheaa4acw_wr_dec #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_dec (
    .addr     (wr_addr),
    .sel      (dec_sel),
    .in_range (dec_ok)
  );

  assign wr_ok = wr_en & dec_ok;

  // ---- stage p0 -> p1: request capture at the rising edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      sel_p1  <= '0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1 <= wr_ok;
      sel_p1 <= wr_ok ? dec_sel : '0;
      if (wr_en)
        data_p1 <= wr_data;
      if (wr_en && !dec_ok)
        err_p1 <= 1'b1;
    end
  end

  // sel_p1 only moves while clk is high, so gating with ~clk cannot glitch an enable low.
  assign lat_en_b    = ~(sel_p1 & {DEPTH{~clk}});
  assign lat_d       = data_p1;
  assign wr_busy     = vld_p1;
  assign wr_addr_err = err_p1;

`ifdef ARF054B256E1R1W0CBBEHEAA4ACW_WR_BYPASS_EN
  logic [AWIDTH-1:0] addr_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      addr_p1 <= '0;
    else
      addr_p1 <= wr_addr;
  end

  assign byp_hit  = rd_en & vld_p1 & (rd_addr == addr_p1);
  assign byp_data = data_p1;
`else
  logic unused_rd;

  assign unused_rd = ^{rd_en, rd_addr};
  assign byp_hit   = 1'b0;
  assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_arf054b256e1r1w0cbbeheaa4acw_wr_stage.sv
// Scoreboard bench: driver pushes expected latch pulses, negedge monitor pops and compares.
module tb_arf054b256e1r1w0cbbeheaa4acw_wr_stage;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [53:0] data;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [53:0]  wr_data;
  logic         rd_en;
  logic [7:0]   rd_addr;
  logic [53:0]  lat_d;
  logic [255:0] lat_en_b;
  logic         byp_hit;
  logic [53:0]  byp_data;
  logic         wr_addr_err;
  logic         wr_busy;

  logic         s_wr_en;
  logic [7:0]   s_wr_addr;
  logic [53:0]  s_wr_data;
  logic         s_rd_en;
  logic [7:0]   s_rd_addr;
  logic [53:0]  s_lat_d;
  logic [199:0] s_lat_en_b;
  logic         s_byp_hit;
  logic [53:0]  s_byp_data;
  logic         s_wr_addr_err;
  logic         s_wr_busy;

  int   checks;
  int   failures;
  int   cyc;
  exp_t q[$];

  arf054b256e1r1w0cbbeheaa4acw_wr_stage dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .lat_d(lat_d), .lat_en_b(lat_en_b),
    .byp_hit(byp_hit), .byp_data(byp_data), .wr_addr_err(wr_addr_err), .wr_busy(wr_busy)
  );

  arf054b256e1r1w0cbbeheaa4acw_wr_stage #(.DWIDTH(54), .DEPTH(200), .AWIDTH(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .lat_d(s_lat_d), .lat_en_b(s_lat_en_b),
    .byp_hit(s_byp_hit), .byp_data(s_byp_data), .wr_addr_err(s_wr_addr_err), .wr_busy(s_wr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Low phase: the staged write (if any) must be the only open latch.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_lat_en_b", lat_en_b, {256{1'b1}});
      chk("rst_lat_d", 256'(lat_d), 256'(0));
      chk("rst_busy", 256'(wr_busy), 256'(0));
      chk("rst_byp_hit", 256'(byp_hit), 256'(0));
    end else begin
      chk("addr_err_256", 256'(wr_addr_err), 256'(0));
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t         e;
        logic [255:0] ev;
        logic         eh;
        e = q.pop_front();
        ev = {256{1'b1}};
        ev[e.addr] = 1'b0;
`ifdef ARF054B256E1R1W0CBBEHEAA4ACW_WR_BYPASS_EN
        eh = rd_en && (rd_addr == e.addr);
`else
        eh = 1'b0;
`endif
        chk("busy", 256'(wr_busy), 256'(1));
        chk("lat_en_b", lat_en_b, ev);
        chk("lat_d", 256'(lat_d), 256'(e.data));
        chk("byp_hit", 256'(byp_hit), 256'(eh));
        if (eh) chk("byp_data", 256'(byp_data), 256'(e.data));
      end else begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
          chk("missed_write_cycle", 256'(q[0].cyc), 256'(cyc));
          void'(q.pop_front());
        end
        chk("idle_busy", 256'(wr_busy), 256'(0));
        chk("idle_lat_en_b", lat_en_b, {256{1'b1}});
        chk("idle_byp_hit", 256'(byp_hit), 256'(0));
      end
    end
  end

  // High phase: every enable is forced closed.
  always @(posedge clk) begin
    #1;
    chk("high_lat_en_b", lat_en_b, {256{1'b1}});
  end

  task automatic drive(input logic we, input logic [7:0] a, input logic [53:0] d,
                       input logic re, input logic [7:0] ra);
    @(posedge clk);
    #1;
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    rd_en   = re;
    rd_addr = ra;
    if (we) q.push_back('{cyc + 1, a, d});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 54'd0, 1'b0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  r64;
    logic [53:0]  rd54;
    logic [7:0]   a;
    logic [7:0]   prev_a;
    logic         we;
    logic         prev_we;
    logic [255:0] sv;

    checks = 0; failures = 0;
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_en = 1'b0; s_rd_addr = '0;

    // Reset held while a write request toggles: nothing may be staged.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      wr_en   = ~wr_en;
      wr_addr = 8'($urandom_range(0, 255));
      r64     = {$urandom, $urandom};
      wr_data = r64[53:0];
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    rst_n = 1'b1;

    // Single write, then back-to-back including the same address.
    drive(1'b1, 8'h2A, 54'h15_5555_5555_5555, 1'b0, 8'd0);
    idle(2);
    drive(1'b1, 8'd3, 54'h0_0000_0000_1111, 1'b0, 8'd0);
    drive(1'b1, 8'd3, 54'h0_0000_0000_2222, 1'b0, 8'd0);
    drive(1'b1, 8'd200, 54'h3F_FFFF_FFFF_FFFF, 1'b0, 8'd0);
    idle(2);

    // Bypass: read of the in-flight address, then a neighbouring one.
    drive(1'b1, 8'd7, 54'hABC, 1'b0, 8'd0);
    drive(1'b1, 8'd7, 54'h123, 1'b1, 8'd7);
    drive(1'b0, 8'd0, 54'd0, 1'b1, 8'd8);
    idle(1);

    // Randomized traffic.
    prev_a = 8'd0; prev_we = 1'b0;
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 3) == 0) ? prev_a : 8'($urandom_range(0, 255));
      r64  = {$urandom, $urandom};
      rd54 = r64[53:0];
      drive(we, a, rd54, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 1 && prev_we) ? prev_a : 8'($urandom_range(0, 255)));
      prev_a = a; prev_we = we;
    end
    idle(2);

    // Reset asserted while entry 5 is open in its low phase.
    drive(1'b1, 8'd5, 54'h5A5A5, 1'b0, 8'd0);
    drive(1'b0, 8'd0, 54'd0, 1'b0, 8'd0);
    @(negedge clk);
    #1;
    chk("pre_abort_en5", 256'(lat_en_b[5]), 256'(0));
    rst_n = 1'b0;
    #1;
    chk("abort_lat_en_b", lat_en_b, {256{1'b1}});
    chk("abort_busy", 256'(wr_busy), 256'(0));
    chk("abort_lat_d", 256'(lat_d), 256'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(3);

    // Non-power-of-two array: out-of-range write is dropped and flagged.
    chk("s_err_init", 256'(s_wr_addr_err), 256'(0));
    @(posedge clk);
    #1;
    s_wr_en = 1'b1; s_wr_addr = 8'd250; s_wr_data = 54'h777;
    @(posedge clk);
    #1;
    s_wr_en = 1'b0;
    @(negedge clk);
    #1;
    chk("s_oor_lat_en_b", 256'(s_lat_en_b), 256'({200{1'b1}}));
    chk("s_oor_busy", 256'(s_wr_busy), 256'(0));
    chk("s_oor_err", 256'(s_wr_addr_err), 256'(1));
    repeat (10) @(posedge clk);
    #1;
    chk("s_err_sticky", 256'(s_wr_addr_err), 256'(1));
    s_wr_en = 1'b1; s_wr_addr = 8'd199; s_wr_data = 54'h1_2345;
    @(posedge clk);
    #1;
    s_wr_en = 1'b0;
    @(negedge clk);
    #1;
    sv = 256'({200{1'b1}});
    sv[199] = 1'b0;
    chk("s_top_lat_en_b", 256'(s_lat_en_b), sv);
    chk("s_top_busy", 256'(s_wr_busy), 256'(1));
    chk("s_top_lat_d", 256'(s_lat_d), 256'(54'h1_2345));
    chk("s_byp_hit", 256'(s_byp_hit), 256'(0));
`ifdef ARF054B256E1R1W0CBBEHEAA4ACW_WR_BYPASS_EN
    chk("s_byp_data", 256'(s_byp_data), 256'(54'h1_2345));
`else
    chk("s_byp_data", 256'(s_byp_data), 256'(0));
`endif
    chk("s_err_still", 256'(s_wr_addr_err), 256'(1));

    idle(2);
    chk("queue_drained", 256'(q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
